// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore FSM sequencing a multi-cycle RV32I datapath, including the
//            memory req/ready handshake, bus-timeout and illegal-opcode traps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       reg_write,
    output logic [1:0] result_sel,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [3:0] alu_op,
    output logic       instr_retired,
    output logic       halted,
    output logic [1:0] trap_cause,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] c_ST_FETCH    = 4'd0;
    localparam logic [3:0] c_ST_DECODE   = 4'd1;
    localparam logic [3:0] c_ST_EXEC_R   = 4'd2;
    localparam logic [3:0] c_ST_EXEC_I   = 4'd3;
    localparam logic [3:0] c_ST_EXEC_U   = 4'd4;
    localparam logic [3:0] c_ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] c_ST_LOAD     = 4'd6;
    localparam logic [3:0] c_ST_STORE    = 4'd7;
    localparam logic [3:0] c_ST_WB_ALU   = 4'd8;
    localparam logic [3:0] c_ST_WB_MEM   = 4'd9;
    localparam logic [3:0] c_ST_BRANCH   = 4'd10;
    localparam logic [3:0] c_ST_JAL      = 4'd11;
    localparam logic [3:0] c_ST_JALR     = 4'd12;
    localparam logic [3:0] c_ST_TRAP     = 4'd13;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_PASS = 4'd10;

    localparam int c_WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [c_WAIT_W-1:0] r_wait;
    logic [1:0]          r_trap_cause;
    logic [1:0]          w_cause;
    logic                w_mem_state;
    logic                w_timeout;
    logic                w_unused;

    assign w_unused = ^{funct7[6], funct7[4:0]};

    // funct3 -> ALU op; alt selects SUB/SRA for the two funct3 codes that have one
    function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f_alu_op = alt ? 4'd1 : 4'd0;
            3'b001:  f_alu_op = 4'd2;
            3'b010:  f_alu_op = 4'd3;
            3'b011:  f_alu_op = 4'd4;
            3'b100:  f_alu_op = 4'd5;
            3'b101:  f_alu_op = alt ? 4'd7 : 4'd6;
            3'b110:  f_alu_op = 4'd8;
            default: f_alu_op = 4'd9;
        endcase
    endfunction

    assign w_mem_state = (r_state == c_ST_FETCH) || (r_state == c_ST_LOAD) ||
                         (r_state == c_ST_STORE);
    // Trap once this wait cycle would bring the count to MAX_WAIT; a ready in the same cycle wins
    assign w_timeout   = (MAX_WAIT != 0) && w_mem_state && !mem_ready &&
                         (int'(r_wait) == MAX_WAIT - 1);

    always_comb begin
        w_next        = r_state;
        w_cause       = 2'b00;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 1'b0;
        reg_write     = 1'b0;
        result_sel    = 2'b00;
        alu_a_sel     = 2'b00;
        alu_b_sel     = 2'b00;
        alu_op        = c_ALU_ADD;
        instr_retired = 1'b0;
        halted        = 1'b0;
        trap_cause    = 2'b00;
        state_dbg     = 4'd0;
        if (!rst) begin
            state_dbg  = r_state;
            trap_cause = r_trap_cause;
            case (r_state)
                c_ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_b_sel = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    alu_a_sel = 2'b01;
                    alu_b_sel = 2'b01;
                    case (opcode)
                        c_OP_R:                  w_next = c_ST_EXEC_R;
                        c_OP_I:                  w_next = c_ST_EXEC_I;
                        c_OP_LOAD, c_OP_STORE:   w_next = c_ST_MEM_ADDR;
                        c_OP_BRANCH:             w_next = c_ST_BRANCH;
                        c_OP_JAL:                w_next = c_ST_JAL;
                        c_OP_JALR:               w_next = c_ST_JALR;
                        c_OP_LUI, c_OP_AUIPC:    w_next = c_ST_EXEC_U;
                        default: begin
                            w_next  = c_ST_TRAP;
                            w_cause = 2'b01;
                        end
                    endcase
                end
                c_ST_EXEC_R: begin
                    alu_a_sel = 2'b10;
                    alu_op    = f_alu_op(funct3, funct7[5]);
                    w_next    = c_ST_WB_ALU;
                end
                c_ST_EXEC_I: begin
                    alu_a_sel = 2'b10;
                    alu_b_sel = 2'b01;
                    alu_op    = f_alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
                    w_next    = c_ST_WB_ALU;
                end
                c_ST_EXEC_U: begin
                    alu_b_sel = 2'b01;
                    if (opcode == c_OP_LUI) begin
                        alu_op = c_ALU_PASS;
                    end else begin
                        alu_a_sel = 2'b01;
                    end
                    w_next = c_ST_WB_ALU;
                end
                c_ST_MEM_ADDR: begin
                    alu_a_sel = 2'b10;
                    alu_b_sel = 2'b01;
                    w_next    = (opcode == c_OP_LOAD) ? c_ST_LOAD : c_ST_STORE;
                end
                c_ST_LOAD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    if (mem_ready) w_next = c_ST_WB_MEM;
                end
                c_ST_STORE: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                    if (mem_ready) begin
                        instr_retired = 1'b1;
                        w_next        = c_ST_FETCH;
                    end
                end
                c_ST_WB_ALU: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    w_next        = c_ST_FETCH;
                end
                c_ST_WB_MEM: begin
                    reg_write     = 1'b1;
                    result_sel    = 2'b01;
                    instr_retired = 1'b1;
                    w_next        = c_ST_FETCH;
                end
                c_ST_BRANCH: begin
                    alu_a_sel     = 2'b10;
                    alu_op        = c_ALU_SUB;
                    pc_write      = branch_taken;
                    pc_sel        = 1'b1;
                    instr_retired = 1'b1;
                    w_next        = c_ST_FETCH;
                end
                c_ST_JAL: begin
                    reg_write     = 1'b1;
                    result_sel    = 2'b10;
                    pc_write      = 1'b1;
                    pc_sel        = 1'b1;
                    instr_retired = 1'b1;
                    w_next        = c_ST_FETCH;
                end
                c_ST_JALR: begin
                    alu_a_sel     = 2'b10;
                    alu_b_sel     = 2'b01;
                    pc_write      = 1'b1;
                    reg_write     = 1'b1;
                    result_sel    = 2'b10;
                    instr_retired = 1'b1;
                    w_next        = c_ST_FETCH;
                end
                c_ST_TRAP: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next = c_ST_FETCH;
                end
            endcase
            if (w_timeout) begin
                w_next = c_ST_TRAP;
                w_cause = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_FETCH;
            r_wait       <= '0;
            r_trap_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if ((w_next == c_ST_TRAP) && (r_state != c_ST_TRAP)) begin
                r_trap_cause <= w_cause;
            end
            // Count only while stalled in the same memory state; any transition clears it
            if (w_mem_state && !mem_ready && (w_next == r_state)) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed scoreboard bench for multicycle_control (MAX_WAIT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel, reg_write;
    logic [1:0] result_sel, alu_a_sel, alu_b_sel, trap_cause;
    logic [3:0] alu_op, state_dbg;
    logic       instr_retired, halted;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, asel, irw, pcw, pcs, rw;
        logic [1:0] rs, as, bs;
        logic [3:0] op;
        logic       ret, halt;
        logic [1:0] tc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    multicycle_control #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
        .reg_write(reg_write), .result_sel(result_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .instr_retired(instr_retired),
        .halted(halted), .trap_cause(trap_cause), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-state output vectors
    function automatic exp_t e_rst();
        e_rst = '0;
    endfunction
    function automatic exp_t e_fetch(input logic rdy);
        e_fetch = '0; e_fetch.st = 4'd0; e_fetch.req = 1'b1;
        e_fetch.irw = rdy; e_fetch.pcw = rdy; e_fetch.bs = 2'd2;
    endfunction
    function automatic exp_t e_decode();
        e_decode = '0; e_decode.st = 4'd1; e_decode.as = 2'd1; e_decode.bs = 2'd1;
    endfunction
    function automatic exp_t e_exec_r(input logic [3:0] op);
        e_exec_r = '0; e_exec_r.st = 4'd2; e_exec_r.as = 2'd2; e_exec_r.op = op;
    endfunction
    function automatic exp_t e_exec_i(input logic [3:0] op);
        e_exec_i = '0; e_exec_i.st = 4'd3; e_exec_i.as = 2'd2; e_exec_i.bs = 2'd1;
        e_exec_i.op = op;
    endfunction
    function automatic exp_t e_exec_u(input logic lui);
        e_exec_u = '0; e_exec_u.st = 4'd4; e_exec_u.bs = 2'd1;
        e_exec_u.as = lui ? 2'd0 : 2'd1; e_exec_u.op = lui ? 4'd10 : 4'd0;
    endfunction
    function automatic exp_t e_mem_addr();
        e_mem_addr = '0; e_mem_addr.st = 4'd5; e_mem_addr.as = 2'd2; e_mem_addr.bs = 2'd1;
    endfunction
    function automatic exp_t e_load();
        e_load = '0; e_load.st = 4'd6; e_load.req = 1'b1; e_load.asel = 1'b1;
    endfunction
    function automatic exp_t e_store(input logic rdy);
        e_store = '0; e_store.st = 4'd7; e_store.req = 1'b1; e_store.we = 1'b1;
        e_store.asel = 1'b1; e_store.ret = rdy;
    endfunction
    function automatic exp_t e_wb_alu();
        e_wb_alu = '0; e_wb_alu.st = 4'd8; e_wb_alu.rw = 1'b1; e_wb_alu.ret = 1'b1;
    endfunction
    function automatic exp_t e_wb_mem();
        e_wb_mem = '0; e_wb_mem.st = 4'd9; e_wb_mem.rw = 1'b1; e_wb_mem.rs = 2'd1;
        e_wb_mem.ret = 1'b1;
    endfunction
    function automatic exp_t e_branch(input logic tk);
        e_branch = '0; e_branch.st = 4'd10; e_branch.as = 2'd2; e_branch.op = 4'd1;
        e_branch.pcw = tk; e_branch.pcs = 1'b1; e_branch.ret = 1'b1;
    endfunction
    function automatic exp_t e_jal();
        e_jal = '0; e_jal.st = 4'd11; e_jal.rw = 1'b1; e_jal.rs = 2'd2;
        e_jal.pcw = 1'b1; e_jal.pcs = 1'b1; e_jal.ret = 1'b1;
    endfunction
    function automatic exp_t e_jalr();
        e_jalr = '0; e_jalr.st = 4'd12; e_jalr.as = 2'd2; e_jalr.bs = 2'd1;
        e_jalr.pcw = 1'b1; e_jalr.rw = 1'b1; e_jalr.rs = 2'd2; e_jalr.ret = 1'b1;
    endfunction
    function automatic exp_t e_trap(input logic [1:0] tc);
        e_trap = '0; e_trap.st = 4'd13; e_trap.halt = 1'b1; e_trap.tc = tc;
    endfunction

    task automatic check(input string tag);
        exp_t x;
        exp_t o;
        x = sb.pop_front();
        o = {state_dbg, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel,
             reg_write, result_sel, alu_a_sel, alu_b_sel, alu_op, instr_retired,
             halted, trap_cause};
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    // One clock cycle: drive inputs away from the edge, queue expectation, sample
    task automatic cyc(input string tag, input logic r, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7, input logic tk,
                       input logic rdy, input exp_t e);
        @(negedge clk);
        rst = r; opcode = opc; funct3 = f3; funct7 = f7; branch_taken = tk; mem_ready = rdy;
        sb.push_back(e);
        #2;
        check(tag);
    endtask

    task automatic instr4(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input exp_t e3);
        cyc({tag, "_fetch"},  1'b0, opc, f3, f7, 1'b0, 1'b1, e_fetch(1'b1));
        cyc({tag, "_decode"}, 1'b0, opc, f3, f7, 1'b0, 1'b1, e_decode());
        cyc({tag, "_exec"},   1'b0, opc, f3, f7, 1'b0, 1'b1, e3);
        cyc({tag, "_wb"},     1'b0, opc, f3, f7, 1'b0, 1'b1, e_wb_alu());
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; branch_taken = 1'b0; mem_ready = 1'b0;

        cyc("reset0", 1'b1, 7'b0110011, 3'd0, 7'd0, 1'b1, 1'b1, e_rst());
        cyc("reset1", 1'b1, 7'b0110011, 3'd0, 7'd0, 1'b1, 1'b1, e_rst());

        instr4("add",   7'b0110011, 3'b000, 7'b0000000, e_exec_r(4'd0));
        instr4("sub",   7'b0110011, 3'b000, 7'b0100000, e_exec_r(4'd1));
        instr4("srl",   7'b0110011, 3'b101, 7'b0000000, e_exec_r(4'd6));
        instr4("and",   7'b0110011, 3'b111, 7'b0000000, e_exec_r(4'd9));
        instr4("srai",  7'b0010011, 3'b101, 7'b0100000, e_exec_i(4'd7));
        instr4("addi7", 7'b0010011, 3'b000, 7'b0100000, e_exec_i(4'd0));
        instr4("xori",  7'b0010011, 3'b100, 7'b0000000, e_exec_i(4'd5));
        instr4("lui",   7'b0110111, 3'b000, 7'b0000000, e_exec_u(1'b1));
        instr4("auipc", 7'b0010111, 3'b000, 7'b0000000, e_exec_u(1'b0));

        // LW with three wait cycles in both memory phases: 11 cycles total
        for (int i = 0; i < 3; i++)
            cyc("lw_fetch_wait", 1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_fetch(1'b0));
        cyc("lw_fetch",    1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("lw_decode",   1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_decode());
        cyc("lw_addr",     1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_mem_addr());
        for (int i = 0; i < 3; i++)
            cyc("lw_load_wait", 1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_load());
        cyc("lw_load",     1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_load());
        cyc("lw_wb",       1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_wb_mem());

        // SW then back-to-back FETCH keeps mem_req high
        cyc("sw_fetch",    1'b0, 7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("sw_decode",   1'b0, 7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1, e_decode());
        cyc("sw_addr",     1'b0, 7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1, e_mem_addr());
        cyc("sw_store_wait", 1'b0, 7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0, e_store(1'b0));
        cyc("sw_store",    1'b0, 7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1, e_store(1'b1));

        for (int t = 0; t < 2; t++) begin
            cyc("beq_fetch",  1'b0, 7'b1100011, 3'b000, 7'd0, 1'(t), 1'b1, e_fetch(1'b1));
            cyc("beq_decode", 1'b0, 7'b1100011, 3'b000, 7'd0, 1'(t), 1'b1, e_decode());
            cyc("beq_branch", 1'b0, 7'b1100011, 3'b000, 7'd0, 1'(t), 1'b1, e_branch(1'(t)));
        end
        cyc("jal_fetch",   1'b0, 7'b1101111, 3'b000, 7'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("jal_decode",  1'b0, 7'b1101111, 3'b000, 7'd0, 1'b0, 1'b1, e_decode());
        cyc("jal_exec",    1'b0, 7'b1101111, 3'b000, 7'd0, 1'b0, 1'b1, e_jal());
        cyc("jalr_fetch",  1'b0, 7'b1100111, 3'b000, 7'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("jalr_decode", 1'b0, 7'b1100111, 3'b000, 7'd0, 1'b0, 1'b1, e_decode());
        cyc("jalr_exec",   1'b0, 7'b1100111, 3'b000, 7'd0, 1'b0, 1'b1, e_jalr());

        // Illegal opcode: sticky trap, then reset clears it
        cyc("ill_fetch",   1'b0, 7'b1110011, 3'b000, 7'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("ill_decode",  1'b0, 7'b1110011, 3'b000, 7'd0, 1'b0, 1'b1, e_decode());
        for (int i = 0; i < 20; i++)
            cyc("ill_trap", 1'b0, 7'(i * 13), 3'(i), 7'd0, 1'(i), 1'(i >> 1), e_trap(2'b01));
        cyc("ill_rst",     1'b1, 7'b0110011, 3'b000, 7'd0, 1'b0, 1'b1, e_rst());
        cyc("ill_after",   1'b0, 7'b0110011, 3'b000, 7'd0, 1'b0, 1'b0, e_fetch(1'b0));

        // Bus timeout: fetch above is wait 1; three more waits then TRAP cause 10
        for (int i = 0; i < 3; i++)
            cyc("to_wait", 1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_fetch(1'b0));
        for (int i = 0; i < 3; i++)
            cyc("to_trap", 1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_trap(2'b10));
        cyc("to_rst",      1'b1, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_rst());

        // Ready on the 4th wait cycle wins over the timeout
        for (int i = 0; i < 3; i++)
            cyc("edge_wait", 1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_fetch(1'b0));
        cyc("edge_fetch",  1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("edge_decode", 1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_decode());
        cyc("edge_addr",   1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_mem_addr());
        cyc("edge_load",   1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_load());
        cyc("edge_load2",  1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_load());

        // Reset mid-LOAD_MEM abandons the request
        cyc("mid_rst",     1'b1, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_rst());
        cyc("mid_fetch",   1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_fetch(1'b1));
        cyc("mid_decode",  1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_decode());
        cyc("mid_addr",    1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_mem_addr());
        cyc("mid_load",    1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_load());
        cyc("mid_wb",      1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1, e_wb_mem());
        cyc("mid_next",    1'b0, 7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0, e_fetch(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM controller sequencing the multi-cycle RV32I datapath: register file, single ALU, ALUOut register, IR, PC/oldPC, and one shared instruction/data memory port.
- Consumes the decoded opcode/funct3/funct7 fields.
- Drives every datapath enable and mux select each cycle.
- Owns the memory req/ready handshake with a bounded-wait timeout.
- Halts in a sticky trap on illegal opcode or bus timeout.

Parameters:
MAX_WAIT, 255, max consecutive cycles with mem_ready low in a memory state before bus-timeout trap; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode  in  7 (opcode_t)  decoded opcode from IR
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]; only bit 5 used
branch_taken  in  1  datapath comparator result for current funct3
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  store (valid with mem_req)
mem_addr_sel  out  1  0=PC, 1=ALUOut
ir_write  out  1  latch instruction into IR
pc_write  out  1  update PC (FETCH also latches oldPC<=PC)
pc_sel  out  1  0=ALU result, 1=ALUOut
reg_write  out  1  regfile write rd
result_sel  out  2  00=ALUOut, 01=mem rdata, 10=PC
alu_a_sel  out  2  00=PC, 01=oldPC, 10=rs1
alu_b_sel  out  2  00=rs2, 01=imm, 10=const 4
alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
instr_retired  out  1  one-cycle pulse in last cycle of each instruction
halted  out  1  FSM in TRAP
trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout
state_dbg  out  4  current state encoding

Behaviour:
- Reset: state<=FETCH, wait counter<=0, trap_cause<=00. While rst is high, all outputs are 0. First post-reset cycle is FETCH.
- ALUOut captures the ALU result every cycle; the datapath implements it.
- Outputs not listed for a state are 0. alu_* selects are don't-care but are driven as 0.
- FETCH: mem_req=1, mem_addr_sel=0, alu PC+4 ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_sel=0, then DECODE.
  - Otherwise hold state.
- DECODE: alu oldPC+imm ADD (branch/JAL target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 or 0010111 -> EXEC_U
  - any other -> TRAP with cause 01
- EXEC_R: rs1 op rs2. funct3 maps to the ALU op; funct7[5] selects SUB for 000 and SRA for 101. Next WB_ALU.
- EXEC_I: rs1 op imm. funct7[5] is honoured only for funct3=101 (SRAI); funct3=000 is always ADD. Next WB_ALU.
- EXEC_U: LUI gives PASS_B of imm; AUIPC gives oldPC+imm ADD. Next WB_ALU.
- MEM_ADDR: rs1+imm ADD. Load -> LOAD_MEM, store -> STORE_MEM.
- LOAD_MEM: mem_req=1, mem_addr_sel=1. On mem_ready -> WB_MEM.
- STORE_MEM: mem_req=1, mem_we=1, mem_addr_sel=1. On mem_ready: instr_retired=1, -> FETCH.
- WB_ALU: reg_write=1, result_sel=00, instr_retired=1, -> FETCH.
- WB_MEM: reg_write=1, result_sel=01, instr_retired=1, -> FETCH.
- BRANCH: rs1 SUB rs2. pc_write=branch_taken, pc_sel=1, instr_retired=1, -> FETCH.
- JAL: reg_write=1, result_sel=10 (PC already holds oldPC+4), pc_write=1, pc_sel=1, instr_retired=1, -> FETCH.
- JALR: rs1+imm ADD, pc_write=1, pc_sel=0 (datapath clears LSB), reg_write=1, result_sel=10, instr_retired=1, -> FETCH. rd==rs1 is safe: read before write edge.
- Latency with mem_ready tied high: R/I/U/store 4 cycles, load 5, branch/JAL/JALR 3.
- Handshake:
  - mem_req rises on entry to FETCH/LOAD_MEM/STORE_MEM and stays high, with constant mem_we/mem_addr_sel, until mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - Back-to-back requests (STORE_MEM -> FETCH) keep mem_req high with no gap.
- Timeout:
  - The wait counter clears on entering a memory state and increments each cycle mem_ready=0.
  - When MAX_WAIT!=0 and the count reaches MAX_WAIT with mem_ready still 0 -> TRAP, cause 10.
  - mem_ready arriving in the same cycle the count reaches MAX_WAIT wins: no trap.
- TRAP: all strobes 0, halted=1, trap_cause held. Leaves only on rst.
- rst mid-instruction: next cycle is FETCH regardless of state. An in-flight memory request is abandoned (mem_req=0 during rst).

Test Plan:
- ADD x3,x1,x2 (opcode 0110011, f7=0000000) with mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_ALU; alu_op 0 in EXEC_R; reg_write and instr_retired in cycle 4 only.
- SUB then SRAI (f7[5]=1, f3=000 R; f3=101 I) -> alu_op 1, then 7. ADDI with f7[5]=1 -> alu_op 0.
- LW with mem_ready delayed 3 cycles in FETCH and LOAD_MEM -> mem_req high continuously 4 cycles each, mem_addr_sel 0 then 1, reg_write with result_sel=01, total 11 cycles.
- BEQ, branch_taken=0 then 1 -> pc_write 0, then 1 with pc_sel=1; JAL -> reg_write with result_sel=10 and pc_write in the same cycle; 3 cycles each.
- opcode 1110011 -> TRAP after DECODE, halted=1, trap_cause=01, no strobes for 20 cycles. rst -> FETCH, trap_cause=00.
- MAX_WAIT=4, mem_ready never asserted in FETCH -> TRAP cause 10 exactly 4 cycles after FETCH entry. Repeat with mem_ready on the 4th wait cycle -> DECODE, no trap. Assert rst mid-LOAD_MEM -> FETCH next cycle.
